// File: rtl/pipeline_redirect_sequencer.sv
// rtl/pipeline_redirect_sequencer.sv - branch_status handshake sequencer with resolve window, flush and abort
// All outputs are registered from next-state, so none has a combinational path from an input.
module pipeline_redirect_sequencer #(
    parameter int                 BRANCH_DELAY = 2,
    parameter int                 STAGES       = 5,
    parameter logic [STAGES-1:0]  FLUSH_MASK   = 5'b00011,
    parameter int                 CNT_W        = 16,
    localparam int                DW           = (BRANCH_DELAY < 1) ? 1 : $clog2(BRANCH_DELAY + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              jump_start,
    input  logic              want_stall,
    input  logic              abort,
    output logic [1:0]        branch_status,
    output logic              busy,
    output logic [STAGES-1:0] flush,
    output logic [DW-1:0]     delay_remaining,
    output logic [CNT_W-1:0]  jump_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [DW-1:0] LOAD = DW'(BRANCH_DELAY);

    state_t              state_q, state_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]    jc_q, jc_d;
    logic [1:0]          bs_q;
    logic                busy_q;
    logic [STAGES-1:0]   flush_q;
    logic [DW-1:0]       dr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        jc_d    = jc_q;
        case (state_q)
            S_IDLE: begin
                if (!abort && jump_start && !want_stall) begin
                    if (BRANCH_DELAY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = LOAD;
                    end else begin
                        state_d = S_REDIRECT;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!want_stall) begin
                    if (cnt_q == DW'(1)) begin
                        state_d = S_REDIRECT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end
            end
            S_REDIRECT: begin
                // The PC write is already committed, so stall cannot extend this cycle.
                state_d = S_IDLE;
                if (!abort && (jc_q != {CNT_W{1'b1}})) begin
                    jc_d = jc_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            jc_q    <= '0;
            bs_q    <= 2'b00;
            busy_q  <= 1'b0;
            flush_q <= '0;
            dr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            jc_q    <= jc_d;
            busy_q  <= (state_d != S_IDLE);
            flush_q <= (state_d == S_REDIRECT) ? FLUSH_MASK : '0;
            dr_q    <= (state_d == S_WAIT) ? cnt_d : '0;
            case (state_d)
                S_WAIT:     bs_q <= 2'b10;
                S_REDIRECT: bs_q <= 2'b11;
                default:    bs_q <= 2'b00;
            endcase
        end
    end

    assign branch_status   = bs_q;
    assign busy            = busy_q;
    assign flush           = flush_q;
    assign delay_remaining = dr_q;
    assign jump_count      = jc_q;

endmodule

// File: tb/tb_pipeline_redirect_sequencer.sv
// tb/tb_pipeline_redirect_sequencer.sv - scoreboard bench for pipeline_redirect_sequencer
module tb_pipeline_redirect_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default build (BRANCH_DELAY=2, CNT_W=16)
    logic        a_rst = 1'b0, a_js = 1'b0, a_ws = 1'b0, a_ab = 1'b0;
    logic [1:0]  a_bs;
    logic        a_busy;
    logic [4:0]  a_fl;
    logic [1:0]  a_dr;
    logic [15:0] a_cnt;

    // DUT B: BRANCH_DELAY=0, CNT_W=2 (back-to-back and saturation)
    logic        b_rst = 1'b0, b_js = 1'b0, b_ws = 1'b0, b_ab = 1'b0;
    logic [1:0]  b_bs;
    logic        b_busy;
    logic [4:0]  b_fl;
    logic [0:0]  b_dr;
    logic [1:0]  b_cnt;

    pipeline_redirect_sequencer u_a (
        .clock(clk), .reset(a_rst), .jump_start(a_js), .want_stall(a_ws), .abort(a_ab),
        .branch_status(a_bs), .busy(a_busy), .flush(a_fl),
        .delay_remaining(a_dr), .jump_count(a_cnt)
    );

    pipeline_redirect_sequencer #(.BRANCH_DELAY(0), .CNT_W(2)) u_b (
        .clock(clk), .reset(b_rst), .jump_start(b_js), .want_stall(b_ws), .abort(b_ab),
        .branch_status(b_bs), .busy(b_busy), .flush(b_fl),
        .delay_remaining(b_dr), .jump_count(b_cnt)
    );

    typedef struct {
        int          idx;
        bit          sel;
        logic [25:0] exp;
    } exp_t;

    exp_t q[$];
    int   applied     = 0;
    int   miscompares = 0;
    int   vec_no      = 0;

    task automatic step(input bit sel, input bit rst, input bit js, input bit ws, input bit ab,
                        input logic [1:0] bs, input logic busy, input logic [4:0] fl,
                        input logic [1:0] dr, input logic [15:0] cnt);
        exp_t e;
        @(negedge clk);
        a_rst = sel ? 1'b0 : rst;  a_js = sel ? 1'b0 : js;
        a_ws  = sel ? 1'b0 : ws;   a_ab = sel ? 1'b0 : ab;
        b_rst = sel ? rst : 1'b0;  b_js = sel ? js : 1'b0;
        b_ws  = sel ? ws : 1'b0;   b_ab = sel ? ab : 1'b0;
        e.idx = vec_no;
        e.sel = sel;
        e.exp = {bs, busy, fl, dr, cnt};
        q.push_back(e);
        vec_no++;
    endtask

    // Monitor: one expected response per clock, sampled 1ns after the edge
    always @(posedge clk) begin
        exp_t        e;
        logic [25:0] act;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel)
                act = {b_bs, b_busy, b_fl, 1'b0, b_dr, 14'd0, b_cnt};
            else
                act = {a_bs, a_busy, a_fl, a_dr, a_cnt};
            applied++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL vec%0d dut_%s: got bs=%b busy=%b flush=%b dr=%0d cnt=%0d, expected bs=%b busy=%b flush=%b dr=%0d cnt=%0d",
                         e.idx, e.sel ? "b" : "a",
                         act[25:24], act[23], act[22:18], act[17:16], act[15:0],
                         e.exp[25:24], e.exp[23], e.exp[22:18], e.exp[17:16], e.exp[15:0]);
            end
        end
    end

    initial begin
        //   sel rst js ws ab   bs     busy fl        dr  cnt
        // reset held with jump_start high
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 0, 2'b00, 0, 5'b00000, 0, 0);
        // nominal redirect
        step(0, 1, 1, 0, 0, 2'b10, 1, 5'b00000, 2, 0);
        step(0, 1, 0, 0, 0, 2'b10, 1, 5'b00000, 1, 0);
        step(0, 1, 0, 0, 0, 2'b11, 1, 5'b00011, 0, 0);
        step(0, 1, 0, 0, 0, 2'b00, 0, 5'b00000, 0, 1);
        // stall in WAIT, jump_start ignored while busy
        step(0, 1, 1, 0, 0, 2'b10, 1, 5'b00000, 2, 1);
        step(0, 1, 0, 0, 0, 2'b10, 1, 5'b00000, 1, 1);
        step(0, 1, 1, 1, 0, 2'b10, 1, 5'b00000, 1, 1);
        step(0, 1, 0, 1, 0, 2'b10, 1, 5'b00000, 1, 1);
        step(0, 1, 1, 1, 0, 2'b10, 1, 5'b00000, 1, 1);
        step(0, 1, 0, 0, 0, 2'b11, 1, 5'b00011, 0, 1);
        // REDIRECT ends after one cycle despite stall; jump_start ignored
        step(0, 1, 1, 1, 0, 2'b00, 0, 5'b00000, 0, 2);
        // abort in WAIT
        step(0, 1, 1, 0, 0, 2'b10, 1, 5'b00000, 2, 2);
        step(0, 1, 0, 0, 0, 2'b10, 1, 5'b00000, 1, 2);
        step(0, 1, 0, 0, 1, 2'b00, 0, 5'b00000, 0, 2);
        step(0, 1, 0, 0, 0, 2'b00, 0, 5'b00000, 0, 2);
        // abort beats jump_start; stall blocks acceptance in IDLE
        step(0, 1, 1, 0, 1, 2'b00, 0, 5'b00000, 0, 2);
        step(0, 1, 1, 1, 0, 2'b00, 0, 5'b00000, 0, 2);
        // abort during REDIRECT: not counted
        step(0, 1, 1, 0, 0, 2'b10, 1, 5'b00000, 2, 2);
        step(0, 1, 0, 0, 0, 2'b10, 1, 5'b00000, 1, 2);
        step(0, 1, 0, 0, 0, 2'b11, 1, 5'b00011, 0, 2);
        step(0, 1, 0, 0, 1, 2'b00, 0, 5'b00000, 0, 2);
        // reset mid-operation clears everything
        step(0, 1, 1, 0, 0, 2'b10, 1, 5'b00000, 2, 2);
        step(0, 0, 0, 0, 0, 2'b00, 0, 5'b00000, 0, 0);
        step(0, 1, 0, 0, 0, 2'b00, 0, 5'b00000, 0, 0);
        // DUT B: zero-delay, jump_start held high, count saturates at 3
        step(1, 1, 1, 0, 0, 2'b11, 1, 5'b00011, 0, 0);
        step(1, 1, 1, 0, 0, 2'b00, 0, 5'b00000, 0, 1);
        step(1, 1, 1, 0, 0, 2'b11, 1, 5'b00011, 0, 1);
        step(1, 1, 1, 0, 0, 2'b00, 0, 5'b00000, 0, 2);
        step(1, 1, 1, 0, 0, 2'b11, 1, 5'b00011, 0, 2);
        step(1, 1, 1, 0, 0, 2'b00, 0, 5'b00000, 0, 3);
        step(1, 1, 1, 0, 0, 2'b11, 1, 5'b00011, 0, 3);
        step(1, 1, 1, 0, 0, 2'b00, 0, 5'b00000, 0, 3);
        step(1, 1, 1, 0, 0, 2'b11, 1, 5'b00011, 0, 3);
        step(1, 1, 1, 0, 0, 2'b00, 0, 5'b00000, 0, 3);
        step(1, 1, 1, 1, 0, 2'b00, 0, 5'b00000, 0, 3);
        step(1, 1, 1, 0, 1, 2'b00, 0, 5'b00000, 0, 3);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            applied++;
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
